semafor_buffer: RTL and testbench

//  Multi-slot semaphore mailbox between one writer core and one reader core of the logic unit.
//  - Holds up to DEPTH words of WIDTH bits.
//  - The writer deposits words; the reader may peek at the oldest word any number of times.
//  - RD together with REALASE consumes the oldest word and frees its slot.
//  - DEPTH=1, WIDTH=1 gives the single-flag write/release semaphore handshake.

---
 rtl/semafor_buffer_pkg.sv | 22 ++
 rtl/semafor_ptr.sv | 42 ++++
 rtl/semafor_buffer.sv | 123 ++++++++++++
 tb/tb_semafor_buffer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/semafor_buffer_pkg.sv
// Shared constants and helpers for the semaphore mailbox.
// Optional status ports (LEVEL/OVF/UNF) are enabled by defining SEMAFOR_BUF_STATUS_EN.
package semafor_buffer_pkg;

    localparam int unsigned DEFAULT_WIDTH = 1;
    localparam int unsigned DEFAULT_DEPTH = 4;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Pointer width: a single-slot buffer still needs a one-bit pointer.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

endpackage

// File: rtl/semafor_ptr.sv
// Wrapping slot pointer with a phase bit that toggles on each wrap.
module semafor_ptr #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic          INC,
    output logic [AW-1:0] PTR,
    output logic          PH
);

    logic [AW-1:0] ptr_q, ptr_d;
    logic          ph_q, ph_d;

    always_comb begin
        ptr_d = ptr_q;
        ph_d  = ph_q;
        if (INC) begin
            if (ptr_q == AW'(DEPTH - 1)) begin
                ptr_d = '0;
                ph_d  = ~ph_q;
            end else begin
                ptr_d = ptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!CLR) begin
            ptr_q <= '0;
            ph_q  <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            ph_q  <= ph_d;
        end
    end

    assign PTR = ptr_q;
    assign PH  = ph_q;

endmodule

// File: rtl/semafor_buffer.sv
// Multi-slot semaphore mailbox between one writer and one reader.
// Define SEMAFOR_BUF_STATUS_EN to add the LEVEL/OVF/UNF status ports.
module semafor_buffer
    import semafor_buffer_pkg::*;
#(
    parameter  int unsigned WIDTH = DEFAULT_WIDTH,
    parameter  int unsigned DEPTH = DEFAULT_DEPTH,
    localparam int unsigned AW    = ptr_width(DEPTH)
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [WIDTH-1:0] DI,
    output logic [WIDTH-1:0] DQ,
    input  logic             WR,
    input  logic             WR_EN,
    output logic             WR_RDY,
    input  logic             RD,
    input  logic             RD_EN,
    output logic             RD_RDY,
    input  logic             REALASE
`ifdef SEMAFOR_BUF_STATUS_EN
    ,
    output logic [AW:0]      LEVEL,
    output logic             OVF,
    output logic             UNF
`endif
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] dq_q, dq_d;
    logic [AW-1:0]    wp, rp, rp_nxt;
    logic             wph, rph, rph_nxt;
    logic             full, empty, we, re, drains;

    semafor_ptr #(.DEPTH(DEPTH), .AW(AW)) u_wptr (
        .CLK (CLK),
        .CLR (CLR),
        .INC (we),
        .PTR (wp),
        .PH  (wph)
    );

    semafor_ptr #(.DEPTH(DEPTH), .AW(AW)) u_rptr (
        .CLK (CLK),
        .CLR (CLR),
        .INC (re),
        .PTR (rp),
        .PH  (rph)
    );

    always_comb begin
        empty   = (wp == rp) && (wph == rph);
        full    = (wp == rp) && (wph != rph);
        WR_RDY  = ~full & WR_EN;
        RD_RDY  = ~empty & RD_EN;
        we      = WR & WR_RDY;
        re      = RD & REALASE & RD_RDY;
        rp_nxt  = (rp == AW'(DEPTH - 1)) ? '0 : rp + AW'(1);
        rph_nxt = (rp == AW'(DEPTH - 1)) ? ~rph : rph;
        // Releasing the last stored word: the read side catches up with the write side.
        drains  = (rp_nxt == wp) && (rph_nxt == wph);
    end

    // DQ always presents the oldest word; a concurrent write refills it when the last word leaves.
    always_comb begin
        dq_d = dq_q;
        if (empty && we) begin
            dq_d = DI;
        end else if (re) begin
            if (!drains) begin
                dq_d = mem_q[rp_nxt];
            end else if (we) begin
                dq_d = DI;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!CLR) begin
            dq_q <= '0;
        end else begin
            dq_q <= dq_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR && we) begin
            mem_q[wp] <= DI;
        end
    end

    assign DQ = dq_q;

`ifdef SEMAFOR_BUF_STATUS_EN
    localparam int unsigned LW = AW + 1;

    logic [AW:0] level_q, level_d;
    logic        ovf_q, ovf_d, unf_q, unf_d;

    always_comb begin
        level_d = level_q + LW'(we) - LW'(re);
        ovf_d   = ovf_q | (WR & WR_EN & full);
        unf_d   = unf_q | (RD & REALASE & RD_EN & empty);
    end

    always_ff @(posedge CLK) begin
        if (!CLR) begin
            level_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign LEVEL = level_q;
    assign OVF   = ovf_q;
    assign UNF   = unf_q;
`endif

endmodule

// File: tb/tb_semafor_buffer.sv
// Bench for semafor_buffer: a DEPTH=4 and a DEPTH=3 instance share stimulus,
// each tracked by its own queue-style occupancy model.
module tb_semafor_buffer;

    logic       clk;
    logic       clr, wr, wr_en, rd, rd_en, rel;
    logic [7:0] di;
    logic [7:0] dq [2];
    logic       wr_rdy [2];
    logic       rd_rdy [2];
`ifdef SEMAFOR_BUF_STATUS_EN
    logic [2:0] level [2];
    logic       ovf [2];
    logic       unf [2];
`endif

    int total = 0;
    int bad   = 0;

    // reference model state: circular list per instance
    logic [7:0] mmem [2][8];
    int         mhead [2];
    int         mcnt [2];
    int         mcap [2];
    logic [7:0] dqm [2];
    logic       movf [2];
    logic       munf [2];

    semafor_buffer #(.WIDTH(8), .DEPTH(4)) u_a (
        .CLK(clk), .CLR(clr), .DI(di), .DQ(dq[0]),
        .WR(wr), .WR_EN(wr_en), .WR_RDY(wr_rdy[0]),
        .RD(rd), .RD_EN(rd_en), .RD_RDY(rd_rdy[0]),
        .REALASE(rel)
`ifdef SEMAFOR_BUF_STATUS_EN
        , .LEVEL(level[0]), .OVF(ovf[0]), .UNF(unf[0])
`endif
    );

    semafor_buffer #(.WIDTH(8), .DEPTH(3)) u_b (
        .CLK(clk), .CLR(clr), .DI(di), .DQ(dq[1]),
        .WR(wr), .WR_EN(wr_en), .WR_RDY(wr_rdy[1]),
        .RD(rd), .RD_EN(rd_en), .RD_RDY(rd_rdy[1]),
        .REALASE(rel)
`ifdef SEMAFOR_BUF_STATUS_EN
        , .LEVEL(level[1]), .OVF(ovf[1]), .UNF(unf[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply current inputs to the model, then advance one clock and settle.
    task automatic step();
        for (int d = 0; d < 2; d++) begin
            bit full, empty, we, re;
            if (!clr) begin
                mcnt[d] = 0; mhead[d] = 0; dqm[d] = 8'h00; movf[d] = 1'b0; munf[d] = 1'b0;
            end else begin
                full  = (mcnt[d] == mcap[d]);
                empty = (mcnt[d] == 0);
                we    = wr && wr_en && !full;
                re    = rd && rel && rd_en && !empty;
                if (wr && wr_en && full) movf[d] = 1'b1;
                if (rd && rel && rd_en && empty) munf[d] = 1'b1;
                if (re) begin
                    mhead[d] = (mhead[d] + 1) % mcap[d];
                    mcnt[d]  = mcnt[d] - 1;
                end
                if (we) begin
                    mmem[d][(mhead[d] + mcnt[d]) % mcap[d]] = di;
                    mcnt[d] = mcnt[d] + 1;
                end
                if (mcnt[d] > 0) dqm[d] = mmem[d][mhead[d]];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr = 1'b0; rd = 1'b0; rel = 1'b0; wr_en = 1'b1; rd_en = 1'b1; clr = 1'b1;
    endtask

    task automatic test_reset();
        clr = 1'b0; wr = 1'b1; rd = 1'b1; rel = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
        di = 8'($urandom);
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            total++;
            if (dq[d] !== 8'h00) begin bad++; $display("FAIL reset_dq dut%0d got=%h exp=00", d, dq[d]); end
            total++;
            if (rd_rdy[d] !== 1'b0) begin bad++; $display("FAIL reset_rd_rdy dut%0d got=%b exp=0", d, rd_rdy[d]); end
            total++;
            if (wr_rdy[d] !== wr_en) begin bad++; $display("FAIL reset_wr_rdy dut%0d got=%b exp=%b", d, wr_rdy[d], wr_en); end
`ifdef SEMAFOR_BUF_STATUS_EN
            total++;
            if (level[d] !== 3'd0 || ovf[d] !== 1'b0 || unf[d] !== 1'b0) begin
                bad++; $display("FAIL reset_status dut%0d got=%0d/%b/%b exp=0/0/0", d, level[d], ovf[d], unf[d]);
            end
`endif
        end
        idle();
        wr_en = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (wr_rdy[d] !== 1'b0) begin bad++; $display("FAIL reset_wr_en_mask dut%0d got=%b exp=0", d, wr_rdy[d]); end
        end
        wr_en = 1'b1;
        step();
    endtask

    task automatic test_fill_drain();
        logic [7:0] words [4];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
        idle();
        for (int i = 0; i < 5; i++) begin
            wr = 1'b1;
            di = (i < 4) ? words[i] : 8'h55;
            step();
            for (int d = 0; d < 2; d++) begin
                total++;
                if (dq[d] !== dqm[d] || wr_rdy[d] !== (mcnt[d] != mcap[d]) || rd_rdy[d] !== 1'b1) begin
                    bad++; $display("FAIL fill dut%0d i=%0d dq=%h/%h wr_rdy=%b rd_rdy=%b", d, i, dq[d], dqm[d], wr_rdy[d], rd_rdy[d]);
                end
            end
        end
        total++;
        if (wr_rdy[0] !== 1'b0 || dq[0] !== 8'h11) begin
            bad++; $display("FAIL fill_full dut0 wr_rdy=%b dq=%h exp 0/11", wr_rdy[0], dq[0]);
        end
`ifdef SEMAFOR_BUF_STATUS_EN
        total++;
        if (ovf[0] !== 1'b1 || level[0] !== 3'd4) begin
            bad++; $display("FAIL fill_ovf dut0 got=%b/%0d exp=1/4", ovf[0], level[0]);
        end
`endif
        wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (dq[0] !== words[i]) begin bad++; $display("FAIL drain_order dut0 i=%0d got=%h exp=%h", i, dq[0], words[i]); end
            rd = 1'b1; rel = 1'b1;
            step();
            for (int d = 0; d < 2; d++) begin
                total++;
                if (dq[d] !== dqm[d] || rd_rdy[d] !== (mcnt[d] != 0)) begin
                    bad++; $display("FAIL drain dut%0d i=%0d dq=%h/%h rd_rdy=%b", d, i, dq[d], dqm[d], rd_rdy[d]);
                end
            end
        end
        total++;
        if (rd_rdy[0] !== 1'b0) begin bad++; $display("FAIL drain_empty dut0 got=%b exp=0", rd_rdy[0]); end
`ifdef SEMAFOR_BUF_STATUS_EN
        total++;
        if (unf[1] !== munf[1] || unf[0] !== munf[0]) begin
            bad++; $display("FAIL drain_unf got=%b/%b exp=%b/%b", unf[0], unf[1], munf[0], munf[1]);
        end
`endif
        idle();
    endtask

    task automatic test_peek();
        idle();
        wr = 1'b1; di = 8'hA5;
        step();
        wr = 1'b0; rd = 1'b1; rel = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            for (int d = 0; d < 2; d++) begin
                total++;
                if (dq[d] !== 8'hA5 || rd_rdy[d] !== 1'b1) begin
                    bad++; $display("FAIL peek dut%0d i=%0d dq=%h rd_rdy=%b exp A5/1", d, i, dq[d], rd_rdy[d]);
                end
            end
        end
        rel = 1'b1;
        step();
        for (int d = 0; d < 2; d++) begin
            total++;
            if (rd_rdy[d] !== 1'b0) begin bad++; $display("FAIL peek_release dut%0d got=%b exp=0", d, rd_rdy[d]); end
        end
        rd = 1'b0; rel = 1'b1;
        wr = 1'b1; di = 8'h3C;
        step();
        wr = 1'b0;
        step();
        for (int d = 0; d < 2; d++) begin
            total++;
            if (rd_rdy[d] !== 1'b1 || dq[d] !== 8'h3C) begin
                bad++; $display("FAIL release_without_rd dut%0d rd_rdy=%b dq=%h exp 1/3c", d, rd_rdy[d], dq[d]);
            end
        end
        rd = 1'b1; rel = 1'b1;
        step();
        idle();
    endtask

    task automatic test_simultaneous();
        logic [7:0] w [4];
        for (int i = 0; i < 4; i++) w[i] = 8'($urandom);
        idle();
        wr = 1'b1; di = w[0]; step();
        di = w[1]; step();
        rd = 1'b1; rel = 1'b1; di = w[2];
        step();
        for (int d = 0; d < 2; d++) begin
            total++;
            if (dq[d] !== w[1] || mcnt[d] != 2) begin
                bad++; $display("FAIL simul_level2 dut%0d dq=%h exp=%h cnt=%0d", d, dq[d], w[1], mcnt[d]);
            end
`ifdef SEMAFOR_BUF_STATUS_EN
            total++;
            if (level[d] !== 3'd2) begin bad++; $display("FAIL simul_level dut%0d got=%0d exp=2", d, level[d]); end
`endif
        end
        wr = 1'b0;
        step();
        step();
        wr = 1'b1; di = w[3];
        step();
        for (int d = 0; d < 2; d++) begin
            total++;
            if (dq[d] !== w[3] || rd_rdy[d] !== 1'b1) begin
                bad++; $display("FAIL simul_empty dut%0d dq=%h exp=%h rd_rdy=%b", d, dq[d], w[3], rd_rdy[d]);
            end
        end
        wr = 1'b0;
        step();
        idle();
    endtask

    task automatic test_wrap_random();
        idle();
        for (int c = 0; c < 300; c++) begin
            wr    = ($urandom_range(0, 2) != 0);
            rd    = ($urandom_range(0, 2) != 0);
            rel   = ($urandom_range(0, 1) != 0);
            wr_en = ($urandom_range(0, 7) != 0);
            rd_en = ($urandom_range(0, 7) != 0);
            di    = 8'($urandom);
            step();
            for (int d = 0; d < 2; d++) begin
                total++;
                if (dq[d] !== dqm[d] || wr_rdy[d] !== ((mcnt[d] != mcap[d]) && wr_en)
                    || rd_rdy[d] !== ((mcnt[d] != 0) && rd_en)) begin
                    bad++; $display("FAIL wrap dut%0d cyc=%0d dq=%h/%h wr_rdy=%b rd_rdy=%b cnt=%0d",
                                    d, c, dq[d], dqm[d], wr_rdy[d], rd_rdy[d], mcnt[d]);
                end
`ifdef SEMAFOR_BUF_STATUS_EN
                total++;
                if (level[d] !== 3'(mcnt[d]) || ovf[d] !== movf[d] || unf[d] !== munf[d]) begin
                    bad++; $display("FAIL wrap_status dut%0d cyc=%0d got=%0d/%b/%b exp=%0d/%b/%b",
                                    d, c, level[d], ovf[d], unf[d], mcnt[d], movf[d], munf[d]);
                end
`endif
            end
        end
        idle();
    endtask

    task automatic test_mid_reset();
        idle();
        for (int i = 0; i < 3; i++) begin
            wr = 1'b1; di = 8'h70 + 8'(i);
            step();
        end
        clr = 1'b0; wr = 1'b1; rd = 1'b1; rel = 1'b1; di = 8'hEE;
        step();
        for (int d = 0; d < 2; d++) begin
            total++;
            if (rd_rdy[d] !== 1'b0 || dq[d] !== 8'h00 || wr_rdy[d] !== 1'b1) begin
                bad++; $display("FAIL midreset dut%0d rd_rdy=%b dq=%h wr_rdy=%b exp 0/00/1", d, rd_rdy[d], dq[d], wr_rdy[d]);
            end
        end
        idle();
        wr = 1'b1; di = 8'h9B;
        step();
        wr = 1'b0;
        step();
        for (int d = 0; d < 2; d++) begin
            total++;
            if (dq[d] !== 8'h9B || rd_rdy[d] !== 1'b1) begin
                bad++; $display("FAIL midreset_new dut%0d dq=%h rd_rdy=%b exp 9b/1", d, dq[d], rd_rdy[d]);
            end
        end
    endtask

    initial begin
        mcap[0] = 4; mcap[1] = 3;
        for (int d = 0; d < 2; d++) begin
            mhead[d] = 0; mcnt[d] = 0; dqm[d] = 8'h00; movf[d] = 1'b0; munf[d] = 1'b0;
        end
        idle();
        clr = 1'b0;
        di  = 8'h00;
        #2;
        test_reset();
        test_fill_drain();
        test_peek();
        test_simultaneous();
        test_wrap_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
